// File: rtl/pe_mac_lanes.sv
// Multi-lane MAC processing element: broadcast activation, per-lane weights, shift-and-narrow output.
// Optional PE_SAT_EN: saturating accumulators, clamped narrowing and per-lane overflow flags.
module pe_mac_lanes #(
    parameter int DW    = 8,
    parameter int ACC_W = 20,
    parameter int OUT_W = 8,
    parameter int LANES = 4,
    parameter int CNT_W = 8,
    parameter int SHIFT = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNT_W-1:0]       len,
    output logic                   busy,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DW-1:0]          in_act,
    input  logic [LANES*DW-1:0]    in_flt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic [LANES-1:0]       out_ovf
);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W-1:0] len_q;
    logic [ACC_W-1:0] acc    [LANES];
    logic [ACC_W-1:0] acc_nx [LANES];
    logic [2*DW-1:0]  prod   [LANES];

    logic [LANES*OUT_W-1:0] res_data;
    logic [LANES-1:0]       res_ovf;

    assign busy      = (state != IDLE);
    assign in_ready  = (state == ACC);
    assign out_valid = (state == DONE);
    assign cnt_nx    = cnt + 1'b1;

`ifdef PE_SAT_EN
    logic [ACC_W:0]   sum [LANES];
    logic [ACC_W-1:0] r   [LANES];

    // A saturated accumulator stays at all-ones: any further add carries out.
    always_comb begin
        res_data = '0;
        res_ovf  = '0;
        for (int i = 0; i < LANES; i++) begin
            prod[i] = {{DW{1'b0}}, in_act} * {{DW{1'b0}}, in_flt[i*DW +: DW]};
            sum[i]  = {1'b0, acc[i]} + {{(ACC_W+1-2*DW){1'b0}}, prod[i]};
            acc_nx[i] = sum[i][ACC_W] ? '1 : sum[i][ACC_W-1:0];
            r[i] = acc_nx[i] >> SHIFT;
            res_ovf[i] = (|r[i][ACC_W-1:OUT_W]) | (&acc_nx[i]);
            res_data[i*OUT_W +: OUT_W] = res_ovf[i] ? '1 : r[i][OUT_W-1:0];
        end
    end
`else
    always_comb begin
        res_data = '0;
        res_ovf  = '0;
        for (int i = 0; i < LANES; i++) begin
            prod[i] = {{DW{1'b0}}, in_act} * {{DW{1'b0}}, in_flt[i*DW +: DW]};
            acc_nx[i] = acc[i] + {{(ACC_W-2*DW){1'b0}}, prod[i]};
            res_data[i*OUT_W +: OUT_W] = OUT_W'(acc_nx[i] >> SHIFT);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            len_q    <= '0;
            out_data <= '0;
            out_ovf  <= '0;
            for (int i = 0; i < LANES; i++) acc[i] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        len_q <= len;
                        cnt   <= '0;
                        for (int i = 0; i < LANES; i++) acc[i] <= '0;
                        if (len != '0) begin
                            state <= ACC;
                        end else begin
                            out_data <= '0;
                            out_ovf  <= '0;
                            state    <= DONE;
                        end
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        cnt <= cnt_nx;
                        for (int i = 0; i < LANES; i++) acc[i] <= acc_nx[i];
                        if (cnt_nx == len_q) begin
                            out_data <= res_data;
                            out_ovf  <= res_ovf;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
